// File: rtl/lenet_frame_capture.sv
// Centre-crops the raster luma stream, box-averages it to an OUT_DIM x OUT_DIM
// image and writes it into the LeNet input buffer, then holds it until LeNet is done.
module lenet_frame_capture #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int X0      = 96,
  parameter int Y0      = 16,
  parameter int BLK     = 16,
  parameter int OUT_DIM = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_sync,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  input  logic       lenet_go,
  input  logic       lenet_ready,
  output logic       buf_we,
  output logic [9:0] buf_addr,
  output logic [7:0] buf_wdata,
  output logic       data_ready,
  output logic [7:0] frames_dropped
);

  localparam int CROP = OUT_DIM * BLK;
  localparam int LB   = $clog2(BLK);
  localparam int CW   = $clog2(IMG_W + 1);
  localparam int RW   = $clog2(IMG_H + 1);
  localparam int BW   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int AW   = $clog2(BLK * BLK * 255 + 1);

  localparam logic [CW-1:0] X_LO   = CW'(X0);
  localparam logic [CW-1:0] X_HI   = CW'(X0 + CROP);
  localparam logic [CW-1:0] W_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] CMASK  = CW'(BLK - 1);
  localparam logic [RW-1:0] Y_LO   = RW'(Y0);
  localparam logic [RW-1:0] Y_HI   = RW'(Y0 + CROP);
  localparam logic [RW-1:0] H_LIM  = RW'(IMG_H);
  localparam logic [RW-1:0] RMASK  = RW'(BLK - 1);
  localparam logic [9:0]    LAST_ADDR = 10'(OUT_DIM * OUT_DIM - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CAPT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] BUSY = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] acc [OUT_DIM];
  logic          seen_low;

  logic          cap_on;
  logic [CW-1:0] col_e;
  logic [RW-1:0] row_e;
  logic          pix_take;
  logic [CW-1:0] cx;
  logic [RW-1:0] cy;
  logic          in_crop;
  logic [BW-1:0] bx;
  logic [BW-1:0] by;
  logic [AW-1:0] acc_cur;
  logic [AW-1:0] sum;
  logic          blk_end;
  logic [9:0]    addr_n;
  logic [7:0]    wdata_n;

  // A frame_sync wins over a coincident pixel: that pixel becomes (0,0) of the new frame.
  always_comb begin
    cap_on   = (state == CAPT) || ((state == IDLE) && frame_sync);
    col_e    = frame_sync ? '0 : col;
    row_e    = frame_sync ? '0 : row;
    pix_take = cap_on && pix_valid && (row_e < H_LIM);
    cx       = col_e - X_LO;
    cy       = row_e - Y_LO;
    in_crop  = pix_take && (col_e >= X_LO) && (col_e < X_HI) &&
               (row_e >= Y_LO) && (row_e < Y_HI);
    bx       = BW'(cx >> LB);
    by       = BW'(cy >> LB);
    acc_cur  = frame_sync ? '0 : acc[bx];
    sum      = acc_cur + AW'(pix_data);
    blk_end  = in_crop && ((cx & CMASK) == CMASK) && ((cy & RMASK) == RMASK);
    addr_n   = 10'(by) * 10'(OUT_DIM) + 10'(bx);
    wdata_n  = 8'(sum >> (2 * LB));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      seen_low       <= 1'b0;
      buf_we         <= 1'b0;
      buf_addr       <= '0;
      buf_wdata      <= '0;
      data_ready     <= 1'b0;
      frames_dropped <= '0;
      for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
    end else begin
      buf_we     <= 1'b0;
      data_ready <= (state == DONE) && !lenet_go;

      if (frame_sync && ((state == DONE) || (state == BUSY)) && (frames_dropped != 8'hFF))
        frames_dropped <= frames_dropped + 8'd1;

      if (cap_on) begin
        if (frame_sync) begin
          col <= '0;
          row <= '0;
          for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
        end
        if (pix_take) begin
          if (col_e == W_LAST) begin
            col <= '0;
            row <= row_e + RW'(1);
          end else begin
            col <= col_e + CW'(1);
          end
        end
        // Completed blocks restart their accumulator for the next block row.
        if (in_crop) acc[bx] <= blk_end ? '0 : sum;
        if (blk_end) begin
          buf_we    <= 1'b1;
          buf_addr  <= addr_n;
          buf_wdata <= wdata_n;
        end
        state <= (blk_end && (addr_n == LAST_ADDR)) ? DONE : CAPT;
      end else begin
        case (state)
          DONE: begin
            if (lenet_go) begin
              state    <= BUSY;
              seen_low <= 1'b0;
            end
          end
          BUSY: begin
            if (!lenet_ready) seen_low <= 1'b1;
            else if (seen_low) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
